// File: rtl/c2c_pkg.sv
// Shared definitions for the chip-to-chip link arbiter: state encoding,
// default timing constants and the rotating-priority pick function.
package c2c_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        SEND = 2'd3
    } state_t;

    localparam int unsigned HOLD_CYCLES_DEF    = 100_000_000;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 200_000_000;

    localparam int MAX_REQ   = 8;
    localparam int IDX_MAX_W = 3;

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] idx;
    } pick_t;

    // Scan ptr, ptr+1, ... wrapping mod n; the lowest offset from ptr wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                      input logic [IDX_MAX_W-1:0] ptr,
                                      input int                   n);
        pick_t p;
        int    i;
        p = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                i = (int'(ptr) + k) % n;
                if (req[i[IDX_MAX_W-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = i[IDX_MAX_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/c2c_hold_timer.sv
// Down-counter that emits a single done pulse CYCLES cycles after load;
// used for the notice hold and, when enabled, the ack-wait timeout.
module c2c_hold_timer
    import c2c_pkg::*;
#(
    parameter int unsigned CYCLES = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Fires in the last loaded cycle so the consumer acts exactly CYCLES edges after load.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/c2c_link_arbiter.sv
// Rotating-priority arbiter sequencing the shared chip-to-chip link handshake.
// Optional ack-wait timeout is built when C2C_TIMEOUT_EN is defined.
module c2c_link_arbiter
    import c2c_pkg::*;
#(
    parameter int          N_REQ          = 4,
    parameter int          DATA_W         = 3,
    parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    input  logic                    ack,
    output logic                    request2s,
    output logic                    valid,
    output logic [DATA_W-1:0]       data,
    output logic [N_REQ-1:0]        grant,
    output logic                    notice,
    output logic [N_REQ-1:0]        served,
    output logic                    err
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    owner, owner_nxt;
    logic [N_REQ-1:0]    grant_nxt, served_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                request2s_nxt, valid_nxt, notice_nxt, err_nxt;
    logic                hold_load, hold_done;
    pick_t               pick;
    logic [IDX_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   slices [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign slices[g] = data_in[g*DATA_W +: DATA_W];
    end

    assign pick     = rr_pick(MAX_REQ'(req), IDX_MAX_W'(ptr), N_REQ);
    assign pick_idx = IDX_W'(pick.idx);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    c2c_hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hold_load),
        .done  (hold_done)
    );

`ifdef C2C_TIMEOUT_EN
    logic tmo_load, tmo_done;

    c2c_hold_timer #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmo_load),
        .done  (tmo_done)
    );
`endif

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        grant_nxt     = grant;
        data_nxt      = data;
        request2s_nxt = request2s;
        valid_nxt     = valid;
        notice_nxt    = notice;
        served_nxt    = '0;
        err_nxt       = 1'b0;
        hold_load     = 1'b0;
`ifdef C2C_TIMEOUT_EN
        tmo_load      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick.found) begin
                    owner_nxt           = pick_idx;
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    data_nxt            = slices[pick_idx];
                    request2s_nxt       = 1'b1;
                    state_nxt           = REQ;
`ifdef C2C_TIMEOUT_EN
                    tmo_load            = 1'b1;
`endif
                end
            end
            REQ: begin
                if (ack) begin
                    request2s_nxt = 1'b0;
                    notice_nxt    = 1'b1;
                    hold_load     = 1'b1;
                    state_nxt     = HOLD;
                end
`ifdef C2C_TIMEOUT_EN
                else if (tmo_done) begin
                    request2s_nxt = 1'b0;
                    grant_nxt     = '0;
                    err_nxt       = 1'b1;
                    ptr_nxt       = next_idx(owner);
                    state_nxt     = IDLE;
                end
`endif
            end
            HOLD: begin
                if (hold_done) begin
                    notice_nxt = 1'b0;
                    valid_nxt  = 1'b1;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                if (!ack) begin
                    valid_nxt  = 1'b0;
                    grant_nxt  = '0;
                    served_nxt = grant;
                    ptr_nxt    = next_idx(owner);
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                grant_nxt     = '0;
                data_nxt      = '0;
                request2s_nxt = 1'b0;
                valid_nxt     = 1'b0;
                notice_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            grant     <= '0;
            data      <= '0;
            request2s <= 1'b0;
            valid     <= 1'b0;
            notice    <= 1'b0;
            served    <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            grant     <= grant_nxt;
            data      <= data_nxt;
            request2s <= request2s_nxt;
            valid     <= valid_nxt;
            notice    <= notice_nxt;
            served    <= served_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_c2c_link_arbiter.sv
// Directed bench for c2c_link_arbiter with HOLD_CYCLES=4, TIMEOUT_CYCLES=10;
// the timeout scenario follows C2C_TIMEOUT_EN.
module tb_c2c_link_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] data_in;
    logic        ack;
    logic        request2s;
    logic        valid;
    logic [2:0]  data;
    logic [3:0]  grant;
    logic        notice;
    logic [3:0]  served;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Payload slices: 0 -> 011, 1 -> 110, 2 -> 101, 3 -> 111
    localparam logic [11:0] DIN = {3'b111, 3'b101, 3'b110, 3'b011};
    logic [2:0] exp_slice [4] = '{3'b011, 3'b110, 3'b101, 3'b111};

    c2c_link_arbiter #(
        .N_REQ          (4),
        .DATA_W         (3),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .request2s (request2s),
        .valid     (valid),
        .data      (data),
        .grant     (grant),
        .notice    (notice),
        .served    (served),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req   = '0;
        ack   = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Slave model: waits for request2s, acks, waits for valid, drops ack.
    task automatic serve_one(output logic [3:0] g, output logic [2:0] d,
                             output logic [3:0] s, output logic ok);
        ok = 1'b1;
        for (int i = 0; i < 20 && !request2s; i++) step();
        if (!request2s) ok = 1'b0;
        g   = grant;
        ack = 1'b1;
        for (int i = 0; i < 20 && !valid; i++) step();
        if (!valid) ok = 1'b0;
        d   = data;
        ack = 1'b0;
        step();
        s = served;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        ack     = 1'b0;
        data_in = DIN;
        step();
        step();
        checks++;
        if ({request2s, valid, notice, err, grant, served, data} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {request2s, valid, notice, err, grant, served, data});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL idle_no_grant: got %b want 0000", grant);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0100;
        step();
        checks++;
        if ({grant, request2s, data} !== {4'b0100, 1'b1, 3'b101}) begin
            errors++;
            $display("FAIL single_grant: got grant=%b req2s=%b data=%b want 0100 1 101",
                     grant, request2s, data);
        end
        req = 4'b0000;
        step();
        step();
        checks++;
        if ({grant, request2s, notice} !== {4'b0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_req_hold: got grant=%b req2s=%b notice=%b want 0100 1 0",
                     grant, request2s, notice);
        end
        ack = 1'b1;
        step();
        checks++;
        if ({request2s, notice, valid} !== 3'b010) begin
            errors++;
            $display("FAIL single_notice_start: got req2s=%b notice=%b valid=%b want 0 1 0",
                     request2s, notice, valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({notice, valid} !== 2'b10) begin
                errors++;
                $display("FAIL single_notice_hold%0d: got notice=%b valid=%b want 1 0",
                         i, notice, valid);
            end
        end
        step();
        checks++;
        if ({notice, valid, data} !== {1'b0, 1'b1, 3'b101}) begin
            errors++;
            $display("FAIL single_valid: got notice=%b valid=%b data=%b want 0 1 101",
                     notice, valid, data);
        end
        ack = 1'b0;
        step();
        checks++;
        if ({valid, grant, served} !== {1'b0, 4'b0000, 4'b0100}) begin
            errors++;
            $display("FAIL single_served: got valid=%b grant=%b served=%b want 0 0000 0100",
                     valid, grant, served);
        end
        step();
        checks++;
        if (served !== 4'b0000) begin
            errors++;
            $display("FAIL single_served_pulse: got %b want 0000", served);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int         idx   [5] = '{0, 1, 2, 3, 0};
        logic [3:0] g, s;
        logic [2:0] d;
        logic       ok;
        apply_reset();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            serve_one(g, d, s, ok);
            if (t == 4) req = 4'b0000;
            checks++;
            if ({ok, g, s, d} !== {1'b1, order[t], order[t], exp_slice[idx[t]]}) begin
                errors++;
                $display("FAIL fair_txn%0d: got ok=%b grant=%b served=%b data=%b want 1 %b %b %b",
                         t, ok, g, s, d, order[t], order[t], exp_slice[idx[t]]);
            end
        end
        step();
    endtask

    task automatic test_skip_wrap();
        logic [3:0] g, s;
        logic [2:0] d;
        logic       ok;
        apply_reset();
        req = 4'b0100;
        serve_one(g, d, s, ok);
        req = 4'b0011;
        serve_one(g, d, s, ok);
        checks++;
        if ({ok, g, d} !== {1'b1, 4'b0001, 3'b011}) begin
            errors++;
            $display("FAIL wrap_first: got ok=%b grant=%b data=%b want 1 0001 011", ok, g, d);
        end
        serve_one(g, d, s, ok);
        req = 4'b0000;
        checks++;
        if ({ok, g, d} !== {1'b1, 4'b0010, 3'b110}) begin
            errors++;
            $display("FAIL wrap_second: got ok=%b grant=%b data=%b want 1 0010 110", ok, g, d);
        end
        step();
    endtask

    task automatic test_stray_ack();
        ack = 1'b1;
        step();
        checks++;
        if ({grant, request2s, notice} !== 6'd0) begin
            errors++;
            $display("FAIL stray_ack: got grant=%b req2s=%b notice=%b want 0000 0 0",
                     grant, request2s, notice);
        end
        ack = 1'b0;
        req = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL held_grant: got %b want 0001", grant);
        end
        req = 4'b0000;
        ack = 1'b1;
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valid, notice} !== 2'b10) begin
                errors++;
                $display("FAIL held_valid%0d: got valid=%b notice=%b want 1 0", i, valid, notice);
            end
            step();
        end
        ack = 1'b0;
        step();
        checks++;
        if ({valid, served} !== {1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL held_release: got valid=%b served=%b want 0 0001", valid, served);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 4'b0010;
        step();
        req = 4'b0000;
        ack = 1'b1;
        step();
        step();
        checks++;
        if ({notice, data} !== {1'b1, 3'b110}) begin
            errors++;
            $display("FAIL mid_in_hold: got notice=%b data=%b want 1 110", notice, data);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({request2s, valid, notice, err, grant, served, data} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b want all zero",
                     {request2s, valid, notice, err, grant, served, data});
        end
        rst_n = 1'b1;
        ack   = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if ({valid, notice, served} !== 6'd0) begin
            errors++;
            $display("FAIL mid_no_resume: got valid=%b notice=%b served=%b want 0 0 0000",
                     valid, notice, served);
        end
        req = 4'b1000;
        step();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL mid_regrant: got %b want 1000", grant);
        end
        apply_reset();
    endtask

    task automatic test_timeout();
`ifdef C2C_TIMEOUT_EN
        logic bad;
        apply_reset();
        req = 4'b0001;
        step();
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            if ({request2s, err} !== 2'b10) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL tmo_early: err or drop before 10 cycles, got req2s=%b err=%b",
                     request2s, err);
        end
        step();
        req = 4'b0011;
        checks++;
        if ({err, grant, request2s, served} !== {1'b1, 4'b0000, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL tmo_fire: got err=%b grant=%b req2s=%b served=%b want 1 0000 0 0000",
                     err, grant, request2s, served);
        end
        step();
        checks++;
        if ({err, grant} !== {1'b0, 4'b0010}) begin
            errors++;
            $display("FAIL tmo_ptr_advance: got err=%b grant=%b want 0 0010", err, grant);
        end
        apply_reset();
`else
        logic bad;
        apply_reset();
        req = 4'b0001;
        step();
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if ({request2s, err, grant} !== {1'b1, 1'b0, 4'b0001}) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_tmo_wait: got req2s=%b err=%b grant=%b want 1 0 0001",
                     request2s, err, grant);
        end
        apply_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_skip_wrap();
        test_stray_ack();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
